fifo_stream_drain: RTL and testbench



---
 rtl/fifo_stream_drain_pkg.sv | 15 +
 rtl/fifo_stream_drain_skid.sv | 51 +++++
 rtl/fifo_stream_drain.sv | 102 ++++++++++
 tb/tb_fifo_stream_drain.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain stage.
package fifo_stream_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } drain_state_e;

  // Depth of the skid buffer that absorbs the FIFO read latency.
  localparam int SKID_DEPTH = 2;
  // Occupancy counter width: must hold 0..SKID_DEPTH.
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_stream_drain_skid.sv
// Two-entry in-order skid buffer. slot0 is the head and drives the stream.
// The caller guarantees no push when full and no pop when empty.
module fifo_stream_drain_skid
  import fifo_stream_drain_pkg::*;
#(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [W-1:0]     head
);

  logic [W-1:0] slot0, slot1;

  assign head = slot0;

  // Occupancy and slot update; push+pop together keeps occ and order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ   <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == '0) slot0 <= din;
          else           slot1 <= din;
          occ <= occ + OCC_W'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - OCC_W'(1);
        end
        2'b11: begin
          if (occ == OCC_W'(1)) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_drain.sv
// Read-side consumer for the synchronous FIFO: issues pops, absorbs the
// one-cycle read latency in a skid buffer and emits a framed valid/ready
// stream with burst last markers, a beat counter and a sticky underflow flag.
module fifo_stream_drain
  import fifo_stream_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  underflow_err,
  output logic [CNT_WIDTH-1:0]  beat_cnt_total
);

  // BURST_LEN=1 still needs a 1-bit index; it simply stays at zero.
  localparam int             IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);

  drain_state_e     state, state_nxt;
  logic             pending;
  logic [OCC_W-1:0] occ;
  logic [IDX_W-1:0] idx;
  logic             hs;

  // Words already held plus the one in flight must leave room for another.
  assign fifo_rd_en = (state == RUN) & ~fifo_empty &
                      (({1'b0, occ} + {{OCC_W{1'b0}}, pending}) < (OCC_W+1)'(SKID_DEPTH));

  assign m_valid = (occ != '0);
  assign hs      = m_valid & m_ready;
  assign m_last  = m_valid & (idx == IDX_LAST);
  assign busy    = (state != IDLE);

  fifo_stream_drain_skid #(
    .W (FIFO_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pending),
    .din   (fifo_data_out),
    .pop   (hs),
    .occ   (occ),
    .head  (m_data)
  );

  // Next-state: STOP waits for the in-flight word and the skid to drain.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP: begin
        if (en)                              state_nxt = RUN;
        else if ((occ == '0) && !pending)    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // In-flight read tracker; reset drops any word still returning.
  always_ff @(posedge clk) begin
    if (!rst_n) pending <= 1'b0;
    else        pending <= fifo_rd_en;
  end

  // Burst index survives STOP/IDLE so framing resumes where it left off.
  always_ff @(posedge clk) begin
    if (!rst_n)  idx <= '0;
    else if (hs) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
  end

  // Total accepted beats, free-running wrap.
  always_ff @(posedge clk) begin
    if (!rst_n)  beat_cnt_total <= '0;
    else if (hs) beat_cnt_total <= beat_cnt_total + CNT_WIDTH'(1);
  end

  // Sticky underflow flag; informational only, never stalls the datapath.
  always_ff @(posedge clk) begin
    if (!rst_n)              underflow_err <= 1'b0;
    else if (fifo_underflow) underflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural FIFO model, data scoreboard,
// table-driven burst scenarios and hand-written stop/underflow/reset cases.
module tb_fifo_stream_drain;

  localparam int W   = 16;
  localparam int BL0 = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en0 = 1'b0, en1 = 1'b0;
  logic         m_ready = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_underflow = 1'b0;
  logic [W-1:0] fifo_data_out = '0;

  logic         rd0, rd1, mv0, mv1, ml0, ml1, busy0, busy1, uerr0, uerr1;
  logic [W-1:0] md0, md1;
  logic [15:0]  cnt0;
  logic [3:0]   cnt1;

  always #5 clk = ~clk;

  fifo_stream_drain #(.FIFO_WIDTH(W), .BURST_LEN(BL0), .CNT_WIDTH(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .fifo_rd_en(rd0),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .m_data(md0), .m_valid(mv0),
    .m_ready(m_ready), .m_last(ml0), .busy(busy0),
    .underflow_err(uerr0), .beat_cnt_total(cnt0)
  );

  fifo_stream_drain #(.FIFO_WIDTH(W), .BURST_LEN(1), .CNT_WIDTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .fifo_rd_en(rd1),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .m_data(md1), .m_valid(mv1),
    .m_ready(m_ready), .m_last(ml1), .busy(busy1),
    .underflow_err(uerr1), .beat_cnt_total(cnt1)
  );

  typedef struct {
    int n;          // words preloaded
    int mode;       // 0: ready=1, 1: toggle, 2: random
    int exp_lasts;  // m_last beats expected in this scenario
    int exp_cnt;    // beat_cnt_total after the scenario
  } vec_t;

  vec_t         vecs[4];
  int           n_cmp = 0, n_bad = 0;
  int           beats = 0, lasts = 0, midx = 0;
  bit           sel = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_d = '0;
  logic [W-1:0] next_word = 16'h0001;
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];

  logic         mv, ml, busy;
  logic [W-1:0] md;
  assign mv   = sel ? mv1   : mv0;
  assign ml   = sel ? ml1   : ml0;
  assign md   = sel ? md1   : md0;
  assign busy = sel ? busy1 : busy0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(next_word);
      exp_q.push_back(next_word);
      next_word++;
    end
    if (n > 0) fifo_empty = 1'b0;
  endtask

  task automatic run_burst(input int n, input int mode);
    int k;
    load(n);
    if (sel) en1 = 1'b1; else en0 = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      k++;
    end
    chk("drain_done", exp_q.size(), 0);
    m_ready = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    k = 0;
    while (busy && k < 20) begin step(); k++; end
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int b0, l0, k;
    bit found;

    vecs[0] = '{8, 0, 2, 8};
    vecs[1] = '{8, 1, 2, 16};
    vecs[2] = '{6, 2, 1, 22};
    vecs[3] = '{2, 1, 1, 24};

    fork
      // FIFO model: registered read, one-cycle latency.
      forever begin
        @(posedge clk);
        if ((rd0 | rd1) && fq.size() > 0) fifo_data_out <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
      end
      // Stream monitor and scoreboard.
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          midx = 0;
          prev_stall = 1'b0;
        end else begin
          chk("rd_en_while_empty", int'((rd0 | rd1) & fifo_empty), 0);
          chk("occ_max", int'(u_dut0.occ > 2'd2), 0);
          if (prev_stall) chk("stall_hold", md, prev_d);
          if (mv && m_ready) begin
            beats++;
            if (ml) lasts++;
            if (exp_q.size() == 0) begin
              chk("unexpected_beat", 1, 0);
            end else begin
              chk("data", md, exp_q.pop_front());
              chk("last", ml, sel ? 1 : int'(midx == BL0 - 1));
              if (!sel) midx = (midx + 1) % BL0;
            end
          end
          prev_stall = mv && !m_ready;
          prev_d = md;
        end
      end
    join_none

    // Reset state
    repeat (3) step();
    chk("rst_m_valid", mv0, 0);
    chk("rst_m_data", md0, 0);
    chk("rst_m_last", ml0, 0);
    chk("rst_rd_en", rd0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_uerr", uerr0, 0);
    chk("rst_cnt", cnt0, 0);
    rst_n = 1'b1;
    step();

    // Table-driven burst scenarios
    for (int i = 0; i < 4; i++) begin
      b0 = beats;
      l0 = lasts;
      run_burst(vecs[i].n, vecs[i].mode);
      chk("vec_beats", beats - b0, vecs[i].n);
      chk("vec_lasts", lasts - l0, vecs[i].exp_lasts);
      chk("vec_cnt", cnt0, vecs[i].exp_cnt);
    end

    // Stop mid-stream with the sink stalled
    b0 = beats;
    load(8);
    en0 = 1'b1;
    m_ready = 1'b1;
    k = 0;
    while (beats < b0 + 3 && k < 50) begin step(); k++; end
    m_ready = 1'b0;
    chk("stop_three_beats", beats - b0, 3);
    repeat (4) step();
    chk("stop_occ_full", u_dut0.occ, 2);
    en0 = 1'b0;
    step();
    chk("stop_busy", busy0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("stop_no_pop", rd0, 0);
      step();
    end
    m_ready = 1'b1;
    k = 0;
    while (busy0 && k < 20) begin step(); k++; end
    chk("stop_drained_beats", beats - b0, 5);
    chk("stop_idle", busy0, 0);
    run_burst(0, 0);
    chk("stop_total_cnt", cnt0, 32);

    // Sticky underflow
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    step();
    chk("uerr_set", uerr0, 1);
    run_burst(4, 2);
    chk("uerr_sticky", uerr0, 1);
    chk("uerr_cnt", cnt0, 36);

    // Reset while a FIFO word is in flight
    load(8);
    en0 = 1'b1;
    m_ready = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      if (u_dut0.pending && u_dut0.occ == 2'd1) found = 1'b1;
      else begin step(); k++; end
    end
    chk("reach_inflight", found, 1);
    rst_n = 1'b0;
    en0 = 1'b0;
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    fq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_valid", mv0, 0);
      chk("mid_rst_cnt", cnt0, 0);
      chk("mid_rst_busy", busy0, 0);
      step();
    end
    chk("mid_rst_uerr", uerr0, 0);

    // BURST_LEN=1, 4-bit counter wraps
    sel = 1'b1;
    b0 = beats;
    l0 = lasts;
    run_burst(20, 0);
    chk("bl1_beats", beats - b0, 20);
    chk("bl1_lasts", lasts - l0, 20);
    chk("bl1_cnt_wrap", cnt1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
